// File: rtl/boc_trk_corr_pkg.sv
// Shared types and helpers for the BOC tracking correlator bank: default widths,
// saturation limits, tracking state encoding and replica sign selection.
package boc_trk_corr_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 24;
    localparam int unsigned ACC_WIDTH_DEF   = 32;
    localparam int unsigned EPOCH_WIDTH_DEF = 16;
    localparam int unsigned LANES           = 6;

    // Wide enough that sign selection and accumulation never wrap before clamping.
    localparam int unsigned CALC_WIDTH = 64;
    typedef logic signed [CALC_WIDTH-1:0] calc_t;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        ACC      = 1'b1
    } trk_state_t;

    function automatic calc_t acc_max(input int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t acc_min(input int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic calc_t chip_sel(input logic chip, input calc_t x);
        return chip ? x : -x;
    endfunction

endpackage

// File: rtl/boc_trk_corr_lane.sv
// One signed saturating correlator lane: chip-signed sample, load on sop,
// accumulate otherwise; sum presents the final value including this sample.
module trk_acc_lane
    import boc_trk_corr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                         rx_clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic                         chip,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [ACC_WIDTH-1:0]  sum
);

    localparam calc_t SAT_MAX = acc_max(ACC_WIDTH);
    localparam calc_t SAT_MIN = acc_min(ACC_WIDTH);

    logic signed [ACC_WIDTH-1:0] acc;
    calc_t                       term;
    calc_t                       base;
    calc_t                       total;

    always_comb begin
        term  = chip_sel(chip, calc_t'(x));
        base  = load ? '0 : calc_t'(acc);
        total = base + term;
        if (total > SAT_MAX) begin
            sum = SAT_MAX[ACC_WIDTH-1:0];
        end else if (total < SAT_MIN) begin
            sum = SAT_MIN[ACC_WIDTH-1:0];
        end else begin
            sum = total[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/boc_trk_corr.sv
// Tracking correlator bank: six E/P/L I/Q lanes integrated per PRN period, dumped
// through a two-stage discriminator pipeline onto a valid/ready interface.
module boc_trk_corr
    import boc_trk_corr_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          rx_trk_rst,
    input  logic signed [DATA_WIDTH-1:0]  rx_data_real,
    input  logic signed [DATA_WIDTH-1:0]  rx_data_imag,
    input  logic                          rx_loc_bocE,
    input  logic                          rx_loc_bocP,
    input  logic                          rx_loc_bocL,
    input  logic                          rx_prn_sop,
    input  logic                          rx_prn_eop,
    input  logic                          rx_corr_ready,
    output logic                          tx_corr_valid,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_ei,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_eq,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_pi,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_pq,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_li,
    output logic signed [ACC_WIDTH-1:0]   tx_corr_lq,
    output logic signed [ACC_WIDTH+1:0]   tx_dll_err,
    output logic [EPOCH_WIDTH-1:0]        tx_epoch,
    output logic                          tx_overrun
);

    trk_state_t                  state;
    logic                        lane_rst;
    logic                        active;
    logic                        dump;
    logic [2:0]                  rep;
    logic signed [ACC_WIDTH-1:0] lane_sum [LANES];

    assign lane_rst = rx_rst | rx_trk_rst;
    assign active   = (state == ACC) | rx_prn_sop;
    assign dump     = active & rx_prn_eop;
    assign rep      = {rx_loc_bocL, rx_loc_bocP, rx_loc_bocE};

    // Lane order: EI, EQ, PI, PQ, LI, LQ.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        trk_acc_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .rx_clk(rx_clk),
            .rst   (lane_rst),
            .en    (active),
            .load  (rx_prn_sop),
            .chip  (rep[g/2]),
            .x     ((g % 2 == 0) ? rx_data_real : rx_data_imag),
            .sum   (lane_sum[g])
        );
    end

    always_ff @(posedge rx_clk) begin
        if (lane_rst) begin
            state <= WAIT_SOP;
        end else if (rx_prn_sop) begin
            state <= rx_prn_eop ? WAIT_SOP : ACC;
        end else if (rx_prn_eop) begin
            state <= WAIT_SOP;
        end
    end

    logic                        s1_valid;
    logic signed [ACC_WIDTH-1:0] s1_sum [LANES];

    always_ff @(posedge rx_clk) begin
        if (lane_rst) begin
            s1_valid <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_sum[i] <= '0;
            end
        end else begin
            s1_valid <= dump;
            if (dump) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_sum[i] <= lane_sum[i];
                end
            end
        end
    end

    // Most-negative sum maps to max positive so the envelope never sees a wrapped magnitude.
    function automatic logic [ACC_WIDTH-1:0] abs_sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v == {1'b1, {(ACC_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return v[ACC_WIDTH-1] ? -v : v;
    endfunction

    logic [ACC_WIDTH:0]          env_e;
    logic [ACC_WIDTH:0]          env_l;
    logic signed [ACC_WIDTH+1:0] dll_next;

    always_comb begin
        env_e    = {1'b0, abs_sat(s1_sum[0])} + {1'b0, abs_sat(s1_sum[1])};
        env_l    = {1'b0, abs_sat(s1_sum[4])} + {1'b0, abs_sat(s1_sum[5])};
        dll_next = $signed({1'b0, env_e}) - $signed({1'b0, env_l});
    end

    always_ff @(posedge rx_clk) begin
        if (lane_rst) begin
            tx_corr_valid <= 1'b0;
            tx_corr_ei    <= '0;
            tx_corr_eq    <= '0;
            tx_corr_pi    <= '0;
            tx_corr_pq    <= '0;
            tx_corr_li    <= '0;
            tx_corr_lq    <= '0;
            tx_dll_err    <= '0;
            tx_epoch      <= '0;
        end else if (s1_valid) begin
            tx_corr_valid <= 1'b1;
            tx_corr_ei    <= s1_sum[0];
            tx_corr_eq    <= s1_sum[1];
            tx_corr_pi    <= s1_sum[2];
            tx_corr_pq    <= s1_sum[3];
            tx_corr_li    <= s1_sum[4];
            tx_corr_lq    <= s1_sum[5];
            tx_dll_err    <= dll_next;
            tx_epoch      <= tx_epoch + 1'b1;
        end else if (rx_corr_ready) begin
            tx_corr_valid <= 1'b0;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            tx_overrun <= 1'b0;
        end else if (!rx_trk_rst && s1_valid && tx_corr_valid && !rx_corr_ready) begin
            tx_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_boc_trk_corr.sv
// Scoreboard bench for boc_trk_corr: a period-level reference model queues expected
// dumps; a negedge monitor tracks presentation, handshake and overrun and compares.
module tb_boc_trk_corr;

    localparam int     DW   = 24;
    localparam int     AW   = 32;
    localparam int     EW   = 16;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                 rx_clk = 1'b0;
    logic                 rx_rst = 1'b1;
    logic                 rx_trk_rst = 1'b0;
    logic signed [DW-1:0] rx_data_real = '0;
    logic signed [DW-1:0] rx_data_imag = '0;
    logic                 rx_loc_bocE = 1'b0;
    logic                 rx_loc_bocP = 1'b0;
    logic                 rx_loc_bocL = 1'b0;
    logic                 rx_prn_sop = 1'b0;
    logic                 rx_prn_eop = 1'b0;
    logic                 rx_corr_ready = 1'b1;
    logic                 tx_corr_valid;
    logic signed [AW-1:0] tx_corr_ei, tx_corr_eq, tx_corr_pi, tx_corr_pq, tx_corr_li, tx_corr_lq;
    logic signed [AW+1:0] tx_dll_err;
    logic [EW-1:0]        tx_epoch;
    logic                 tx_overrun;

    boc_trk_corr #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .EPOCH_WIDTH(EW)
    ) dut (
        .rx_clk       (rx_clk),
        .rx_rst       (rx_rst),
        .rx_trk_rst   (rx_trk_rst),
        .rx_data_real (rx_data_real),
        .rx_data_imag (rx_data_imag),
        .rx_loc_bocE  (rx_loc_bocE),
        .rx_loc_bocP  (rx_loc_bocP),
        .rx_loc_bocL  (rx_loc_bocL),
        .rx_prn_sop   (rx_prn_sop),
        .rx_prn_eop   (rx_prn_eop),
        .rx_corr_ready(rx_corr_ready),
        .tx_corr_valid(tx_corr_valid),
        .tx_corr_ei   (tx_corr_ei),
        .tx_corr_eq   (tx_corr_eq),
        .tx_corr_pi   (tx_corr_pi),
        .tx_corr_pq   (tx_corr_pq),
        .tx_corr_li   (tx_corr_li),
        .tx_corr_lq   (tx_corr_lq),
        .tx_dll_err   (tx_dll_err),
        .tx_epoch     (tx_epoch),
        .tx_overrun   (tx_overrun)
    );

    always #5 rx_clk = ~rx_clk;

    int unsigned cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned appear;
        longint      v[6];
        longint      dll;
    } dump_t;

    dump_t  sbq[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     ready_mode = 0;
    bit     in_period = 0;
    longint s[6];

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint abss(input longint v);
        if (v == SMIN) return SMAX;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rnd_data();
        logic [DW-1:0] r;
        r = DW'($urandom);
        case ($urandom_range(0, 7))
            0:       return -(1 <<< (DW - 1));
            1:       return (1 <<< (DW - 1)) - 1;
            default: return int'($signed(r));
        endcase
    endfunction

    // One clock of stimulus plus the reference model's view of that sample.
    task automatic drive(input bit rst, input bit trk, input bit sop, input bit eop,
                         input int re, input int im, input bit e, input bit p, input bit l);
        dump_t  d;
        longint xv, t;
        bit     c;
        @(posedge rx_clk);
        #1;
        rx_rst        = rst;
        rx_trk_rst    = trk;
        rx_prn_sop    = sop;
        rx_prn_eop    = eop;
        rx_data_real  = re[DW-1:0];
        rx_data_imag  = im[DW-1:0];
        rx_loc_bocE   = e;
        rx_loc_bocP   = p;
        rx_loc_bocL   = l;
        rx_corr_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (rst || trk) begin
            in_period = 0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                xv = (i % 2 == 0) ? longint'(re) : longint'(im);
                c  = (i < 2) ? e : (i < 4) ? p : l;
                t  = c ? xv : -xv;
                if (sop) s[i] = t;
                else if (in_period) s[i] = sat(s[i] + t);
            end
            if (sop) in_period = 1;
            if (in_period && eop) begin
                d.appear = cyc + 2;
                d.v      = s;
                d.dll    = abss(s[0]) + abss(s[1]) - abss(s[4]) - abss(s[5]);
                sbq.push_back(d);
                in_period = 0;
            end
        end
    endtask

    task automatic sample(input bit sop, input bit eop, input int re, input int im,
                          input bit e, input bit p, input bit l);
        drive(0, 0, sop, eop, re, im, e, p, l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sample(0, 0, rnd_data(), rnd_data(), 1, 1, 1);
    endtask

    task automatic period(input int n, input int re, input int im, input bit e, input bit p, input bit l);
        for (int i = 0; i < n; i++) sample(i == 0, i == n - 1, re, im, e, p, l);
    endtask

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: expected presented state evolves from what was driven last cycle.
    bit            exp_valid = 0;
    bit            exp_ovr = 0;
    logic [EW-1:0] exp_epoch = '0;
    longint        cur[6] = '{default: 0};
    longint        cur_dll = 0;
    bit            l_rst = 1, l_trk = 0, l_ready = 1;

    always @(negedge rx_clk) begin
        dump_t d;
        if (l_rst || l_trk) begin
            exp_valid = 0;
            exp_epoch = '0;
            cur       = '{default: 0};
            cur_dll   = 0;
            if (l_rst) exp_ovr = 0;
            while (sbq.size() > 0 && sbq[0].appear <= cyc + 1) void'(sbq.pop_front());
        end else begin
            if (exp_valid && l_ready) exp_valid = 0;
            if (sbq.size() > 0 && sbq[0].appear == cyc) begin
                d = sbq.pop_front();
                if (exp_valid) exp_ovr = 1;
                exp_valid = 1;
                exp_epoch = exp_epoch + 1'b1;
                cur       = d.v;
                cur_dll   = d.dll;
            end
        end
        check("valid",   longint'(tx_corr_valid), longint'(exp_valid));
        check("overrun", longint'(tx_overrun),    longint'(exp_ovr));
        check("epoch",   longint'(tx_epoch),      longint'(exp_epoch));
        check("ei",      longint'(tx_corr_ei),    cur[0]);
        check("eq",      longint'(tx_corr_eq),    cur[1]);
        check("pi",      longint'(tx_corr_pi),    cur[2]);
        check("pq",      longint'(tx_corr_pq),    cur[3]);
        check("li",      longint'(tx_corr_li),    cur[4]);
        check("lq",      longint'(tx_corr_lq),    cur[5]);
        check("dll_err", longint'(tx_dll_err),    cur_dll);
        l_rst   = rx_rst;
        l_trk   = rx_trk_rst;
        l_ready = rx_corr_ready;
    end

    initial begin
        int len;
        bit e;
        for (int i = 0; i < 6; i++) s[i] = 0;
        ready_mode = 0;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        period(4, 100, -50, 1, 1, 1);
        idle(3);

        period(8, 10, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) sample(i == 0, i == 7, 10, 0, (i % 2) == 0, 1, 0);
        idle(3);

        sample(1, 1, -7, 3, 1, 0, 1);
        idle(3);

        period(600, 8388607, 0, 1, 1, 0);
        period(600, -8388608, 3, 1, 1, 1);
        idle(3);

        sample(1, 0, 5, 5, 1, 1, 1);
        sample(0, 1, 5, 5, 1, 1, 1);
        sample(0, 1, 9, 9, 1, 1, 1);
        idle(2);

        ready_mode = 1;
        period(4, 1, 2, 1, 0, 1);
        period(4, 3, 4, 0, 1, 1);
        idle(4);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        ready_mode = 0;
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3; i++) sample(i == 0, 0, 1000, -1000, 1, 1, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        period(4, 2, -3, 1, 0, 1);
        idle(3);

        for (int it = 0; it < 80; it++) begin
            ready_mode = $urandom_range(0, 2);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                sample(0, $urandom_range(0, 3) == 0, rnd_data(), rnd_data(), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                if (k > 0 && $urandom_range(0, 39) == 0) begin
                    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
                    break;
                end
                e = 1'($urandom);
                sample(k == 0 || $urandom_range(0, 19) == 0, k == len - 1, rnd_data(), rnd_data(),
                       e, 1'($urandom), 1'($urandom));
            end
        end

        ready_mode = 0;
        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boc_trk_corr.md
Name: boc_trk_corr

Overview:
- Tracking-side correlator bank directly downstream of the BOC acquisition stage.
- Consumes the carrier-wiped samples (real/imag mixer products) together with the acquisition stage's early/prompt/late local BOC replicas, code-period markers and tracking reset.
- Integrates six correlator sums (EI, EQ, PI, PQ, LI, LQ) over one PRN period and dumps them with an early-minus-late envelope error.
- Results are presented through a valid/ready handshake to the loop-filter stage.

Parameters:
- DATA_WIDTH, 24, signed width of rx_data_real / rx_data_imag
- ACC_WIDTH, 32, signed width of each accumulator and dumped sum
- EPOCH_WIDTH, 16, width of the dump epoch counter

Ports:
- rx_clk  in  1  system clock; all logic on rising edge
- rx_rst  in  1  synchronous, active-high reset
- rx_trk_rst  in  1  tracking restart from acquisition; synchronous, active-high
- rx_data_real  in  DATA_WIDTH  signed in-phase mixer product, one sample per clock
- rx_data_imag  in  DATA_WIDTH  signed quadrature mixer product
- rx_loc_bocE  in  1  early replica chip, 1 = +1, 0 = -1
- rx_loc_bocP  in  1  prompt replica chip
- rx_loc_bocL  in  1  late replica chip
- rx_prn_sop  in  1  first sample of PRN period
- rx_prn_eop  in  1  last sample of PRN period
- rx_corr_ready  in  1  consumer accepts dump
- tx_corr_valid  out  1  dump available
- tx_corr_ei, tx_corr_eq, tx_corr_pi, tx_corr_pq, tx_corr_li, tx_corr_lq  out  ACC_WIDTH each  dumped signed sums
- tx_dll_err  out  ACC_WIDTH+2  signed (|EI|+|EQ|) - (|LI|+|LQ|)
- tx_epoch  out  EPOCH_WIDTH  index of the presented dump
- tx_overrun  out  1  sticky: a dump was lost

Behaviour:
- Clock and reset: single clock rx_clk; rx_rst is synchronous, active-high.
- Reset values: rx_rst or rx_trk_rst clears all accumulators, pipeline and outputs to 0, and sets state WAIT_SOP. tx_overrun is cleared by rx_rst only; it is held through rx_trk_rst.
- State WAIT_SOP:
  - Samples are ignored.
  - rx_prn_sop → ACC; that sample is loaded, not added.
  - A cycle with rx_prn_eop but no sop in WAIT_SOP is ignored.
- State ACC:
  - Each clock, lane X for replica R computes acc_XR ← acc_XR + (R ? x : -x), for X ∈ {I: real, Q: imag}.
  - On rx_prn_sop, the accumulator is loaded with ±x instead of added.
- Saturation:
  - Accumulation saturates at +(2^(ACC_WIDTH-1)-1) / -(2^(ACC_WIDTH-1)).
  - -x is computed at DATA_WIDTH+1 bits; no wrap.
- Dump (rx_prn_eop in ACC, cycle N):
  - The final sums, including the eop sample, are registered into stage-1 at edge N+1.
  - Stage-2 registers the sums, envelopes and tx_dll_err at N+2, asserts tx_corr_valid, and increments tx_epoch (wraps modulo 2^EPOCH_WIDTH).
  - Fixed latency: 2 cycles from eop to valid.
- sop and eop in the same cycle: one-sample period; load and dump that single sample.
- eop followed by sop on the next cycle is the normal case. If no sop follows, the state returns to WAIT_SOP.
- Handshake:
  - Outputs are stable while tx_corr_valid && !rx_corr_ready.
  - valid && ready completes the transfer; valid drops next cycle unless a new dump lands the same edge.
- New stage-2 dump while valid && !ready: overwrite the outputs, keep valid, set tx_overrun.
- New dump while valid && ready: accepted in place; valid stays high, no overrun.
- rx_trk_rst mid-period: the partial period is discarded, no dump is issued, and any pending valid is dropped.
- |x| of the most-negative value saturates to its max positive before the envelope sum.

Decomposition:
- Shared package: DATA_WIDTH/ACC_WIDTH defaults, saturation limit constants, state encoding (WAIT_SOP, ACC), and the sign-select helper function.
- Natural sub-module: trk_acc_lane (one signed saturating load/accumulate lane, chip-sign select, sop-load, eop final-sum output), instantiated six times.
- The handshake and discriminator pipeline stays in the top module.

Test Plan:
- Constant real=+100, imag=-50, all replicas=1, period 4 samples (sop@0, eop@3) → valid at cycle 5; EI=PI=LI=400, EQ=PQ=LQ=-200, dll_err=0, epoch=1.
- E=1 always, L=0 always, real=+10, imag=0, period 8, ready=1 → EI=80, LI=-80, dll_err=0; then E alternating chips → EI=0, dll_err=-80.
- sop and eop in same cycle, real=-7 → EI=-7 with replica E=1, latency still 2 cycles.
- Real=+(2^23-1) for 600 samples with ACC_WIDTH=32 → EI saturates at 2147483647, no sign flip.
- ready=0 across two consecutive periods → second dump overwrites first, tx_overrun=1; rx_trk_rst does not clear it, rx_rst does.
- rx_trk_rst asserted mid-period after 3 samples → no dump; next sop-eop period of 4 samples dumps only those 4 samples.
